// File: rtl/sopc_dbus_bridge.sv
// Data-bus bridge: decodes the CPU data port onto NUM_SLV slaves, stalls the
// CPU until the selected slave acks, and reports unmapped or timed-out accesses.
module sopc_dbus_bridge #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLV     = 4,
  parameter int REGION_BITS = 28,
  parameter int TIMEOUT     = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_ce_i,
  input  logic                      cpu_we_i,
  input  logic [DATA_W/8-1:0]       cpu_sel_i,
  input  logic [ADDR_W-1:0]         cpu_addr_i,
  input  logic [DATA_W-1:0]         cpu_data_i,
  output logic [DATA_W-1:0]         cpu_data_o,
  output logic                      cpu_stall_o,
  output logic                      cpu_err_o,
  output logic [NUM_SLV-1:0]        slv_cyc_o,
  output logic                      slv_we_o,
  output logic [DATA_W/8-1:0]       slv_sel_o,
  output logic [ADDR_W-1:0]         slv_addr_o,
  output logic [DATA_W-1:0]         slv_data_o,
  input  logic [NUM_SLV*DATA_W-1:0] slv_data_i,
  input  logic [NUM_SLV-1:0]        slv_ack_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = ADDR_W - REGION_BITS;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_r;
  logic [NUM_SLV-1:0]  cyc_r;
  logic                we_r;
  logic [SEL_W-1:0]    sel_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                err_r;
  logic [CNT_W-1:0]    cnt_r;

  logic [IDX_W-1:0]    idx_s;
  logic [NUM_SLV-1:0]  dec_s;
  logic                ack_s;
  logic [DATA_W-1:0]   rdata_s;
  logic                timeout_s;

  // Region decode of the incoming CPU address into a one-hot slave select
  always_comb begin
    idx_s = cpu_addr_i[ADDR_W-1:REGION_BITS];
    dec_s = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_s == IDX_W'(i)) begin
        dec_s[i] = 1'b1;
      end else begin
        dec_s[i] = 1'b0;
      end
    end
  end

  // Ack and read data of the currently selected slave only; cyc is one-hot
  always_comb begin
    ack_s   = |(slv_ack_i & cyc_r);
    rdata_s = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (cyc_r[i]) begin
        rdata_s = rdata_s | slv_data_i[i*DATA_W +: DATA_W];
      end else begin
        rdata_s = rdata_s;
      end
    end
    timeout_s = (cnt_r == CNT_W'(TIMEOUT - 1));
  end

  // Transaction FSM with registered bus and CPU response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cyc_r   <= '0;
      we_r    <= 1'b0;
      sel_r   <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      err_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          err_r <= 1'b0;
          if (cpu_ce_i) begin
            we_r    <= cpu_we_i;
            sel_r   <= cpu_sel_i;
            addr_r  <= cpu_addr_i;
            wdata_r <= cpu_data_i;
            cnt_r   <= '0;
            if (|dec_s) begin
              cyc_r   <= dec_s;
              state_r <= ST_BUSY;
            end else begin
              cyc_r   <= '0;
              err_r   <= 1'b1;
              rdata_r <= '0;
              state_r <= ST_DONE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // An ack arriving on the final allowed cycle still wins over timeout
          if (ack_s) begin
            if (!we_r) begin
              rdata_r <= rdata_s;
            end else begin
              rdata_r <= rdata_r;
            end
            cyc_r   <= '0;
            state_r <= ST_DONE;
          end else if (timeout_s) begin
            cyc_r   <= '0;
            err_r   <= 1'b1;
            rdata_r <= '0;
            state_r <= ST_DONE;
          end else begin
            if (cnt_r != {CNT_W{1'b1}}) begin
              cnt_r <= cnt_r + CNT_W'(1);
            end else begin
              cnt_r <= cnt_r;
            end
          end
        end
        ST_DONE: begin
          err_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          cyc_r   <= '0;
          err_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_stall_o = ((state_r == ST_IDLE) && cpu_ce_i) || (state_r == ST_BUSY);
  assign cpu_data_o  = rdata_r;
  assign cpu_err_o   = err_r;
  assign slv_cyc_o   = cyc_r;
  assign slv_we_o    = we_r;
  assign slv_sel_o   = sel_r;
  assign slv_addr_o  = addr_r;
  assign slv_data_o  = wdata_r;

endmodule
